// File: rtl/rc4_pkg.sv
// -----------------------------------------------------------------------------
// rc4_pkg
// Shared types and constants for the RC4 stream cipher slice.
//   SBOX_SIZE : number of S-box entries (one per byte value)
//   byte_t    : 8-bit datapath word
//   state_t   : controller states (IDLE, FILL, KSA, DROP, RUN)
// -----------------------------------------------------------------------------
package rc4_pkg;

   localparam int SBOX_SIZE = 256;

   typedef logic [7:0] byte_t;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      KSA,
      DROP,
      RUN
   } state_t;

endpackage

// File: rtl/rc4_keystream.sv
// -----------------------------------------------------------------------------
// rc4_keystream
// RC4 state machine datapath: 256-entry S-box with combinational read, the
// i/j index registers, and the three update operations (identity fill, key
// scheduling step, keystream generation step). Sequencing is owned by the
// parent; this block only executes the operation it is told to.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (clears i and j)
//   clear     : zero i and j (rekey); highest priority
//   fill      : S[i] = i, i++
//   ksa       : j += S[i] + key_byte, swap S[i]/S[j], i++ (j zeroed after i=255)
//   step      : one keystream step; ks is the byte produced by that step
//   key_byte  : key byte for the current KSA index
//   idx       : current i (parent uses it to detect the end of FILL/KSA)
//   ks        : keystream byte the next step would produce
// -----------------------------------------------------------------------------
module rc4_keystream
   import rc4_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  clear,
   input  logic  fill,
   input  logic  ksa,
   input  logic  step,
   input  byte_t key_byte,
   output byte_t idx,
   output byte_t ks
);

   byte_t sbox [SBOX_SIZE];
   byte_t i_q;
   byte_t j_q;

   byte_t s_i;
   byte_t j_ksa;
   byte_t s_j_ksa;
   byte_t i_nxt;
   byte_t s_i_nxt;
   byte_t j_nxt;
   byte_t s_j_nxt;
   byte_t ks_idx;

   // All sums wrap naturally at 8 bits. The keystream index uses pre-swap
   // values, which add up to the same result as the post-swap pair.
   always_comb begin
      s_i     = sbox[i_q];
      j_ksa   = j_q + s_i + key_byte;
      s_j_ksa = sbox[j_ksa];
      i_nxt   = i_q + 8'd1;
      s_i_nxt = sbox[i_nxt];
      j_nxt   = j_q + s_i_nxt;
      s_j_nxt = sbox[j_nxt];
      ks_idx  = s_i_nxt + s_j_nxt;
   end

   assign ks  = sbox[ks_idx];
   assign idx = i_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, whatever the statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_q <= '0;
         j_q <= '0;
      end else if (clear) begin
         i_q <= '0;
         j_q <= '0;
      end else if (fill) begin
         i_q <= i_nxt;
      end else if (ksa) begin
         i_q <= i_nxt;
         j_q <= (i_q == 8'hFF) ? 8'h00 : j_ksa;
      end else if (step) begin
         i_q <= i_nxt;
         j_q <= j_nxt;
      end
   end

   // NOTE: the S-box has no reset; FILL rewrites every entry before use, and
   // leaving it out of the reset tree keeps it a plain register file.
   // When both swap indices coincide the two writes carry the same value.
   always_ff @(posedge clk) begin
      if (!clear) begin
         if (fill) begin
            sbox[i_q] <= i_q;
         end else if (ksa) begin
            sbox[i_q]   <= s_j_ksa;
            sbox[j_ksa] <= s_i;
         end else if (step) begin
            sbox[i_nxt] <= s_j_nxt;
            sbox[j_nxt] <= s_i_nxt;
         end
      end
   end

endmodule

// File: rtl/rc4_stream_cipher.sv
// -----------------------------------------------------------------------------
// rc4_stream_cipher
// RC4 byte stream cipher (encrypt == decrypt) with on-chip key scheduling and
// valid/ready handshakes on both sides. A legal start pulse (re)keys at any
// time, aborting any stream in progress.
// Configuration macro: RC4_DROP_EN -- when defined, the first DROP_N keystream
// bytes after every key schedule are discarded (RC4-drop[N]).
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   key, key_len      : key (byte k at key[8k+7:8k]) and its length, sampled on start
//   start             : single-cycle rekey pulse (ignored if key_len is illegal)
//   s_data/valid/ready: input byte stream
//   m_data/valid/ready: output byte stream (s_data XOR keystream), 1-cycle latency
//   init_done         : keystream ready (RUN)
//   busy              : initialising (FILL, KSA, DROP)
// -----------------------------------------------------------------------------
module rc4_stream_cipher
   import rc4_pkg::*;
#(
   parameter  int KEY_BYTES = 16,
   parameter  int DROP_N    = 256,
   localparam int KLW       = $clog2(KEY_BYTES + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [KEY_BYTES*8-1:0] key,
   input  logic [KLW-1:0]         key_len,
   input  logic                   start,
   input  logic [7:0]             s_data,
   input  logic                   s_valid,
   output logic                   s_ready,
   output logic [7:0]             m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic                   init_done,
   output logic                   busy
);

   state_t                 state;
   logic [KEY_BYTES*8-1:0] key_q;
   logic [KLW-1:0]         key_len_q;
   logic [KLW-1:0]         kidx;

   logic  start_ok;
   logic  accept;
   logic  ks_fill;
   logic  ks_ksa;
   logic  ks_step;
   byte_t key_byte;
   byte_t ks_idx;
   byte_t ks;

`ifdef RC4_DROP_EN
   logic [15:0] drop_cnt;
`endif

   assign start_ok = start && (key_len != '0) && (key_len <= KLW'(KEY_BYTES));

   // A rekey pulse wins over a same-cycle input handshake.
   assign s_ready = (state == RUN) && (!m_valid || m_ready) && !start_ok;
   assign accept  = s_valid && s_ready;

   // kidx walks 0..key_len-1 in step with i, replacing i mod key_len.
   assign key_byte = key_q[{kidx, 3'b000} +: 8];

   assign ks_fill = (state == FILL);
   assign ks_ksa  = (state == KSA);
`ifdef RC4_DROP_EN
   assign ks_step = accept || (state == DROP);
`else
   assign ks_step = accept;
`endif

   rc4_keystream u_keystream (
      .clk      (clk),
      .rst      (rst),
      .clear    (start_ok),
      .fill     (ks_fill),
      .ksa      (ks_ksa),
      .step     (ks_step),
      .key_byte (key_byte),
      .idx      (ks_idx),
      .ks       (ks)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         key_q     <= '0;
         key_len_q <= '0;
         kidx      <= '0;
         m_data    <= '0;
         m_valid   <= 1'b0;
         init_done <= 1'b0;
         busy      <= 1'b0;
`ifdef RC4_DROP_EN
         drop_cnt  <= '0;
`endif
      end else if (start_ok) begin
         // Rekey from any state; a pending output byte is dropped.
         state     <= FILL;
         key_q     <= key;
         key_len_q <= key_len;
         kidx      <= '0;
         m_valid   <= 1'b0;
         init_done <= 1'b0;
         busy      <= 1'b1;
      end else begin
         case (state)
            FILL: begin
               if (ks_idx == 8'hFF) begin
                  state <= KSA;
                  kidx  <= '0;
               end
            end

            KSA: begin
               kidx <= (kidx == key_len_q - KLW'(1)) ? '0 : kidx + KLW'(1);
               if (ks_idx == 8'hFF) begin
`ifdef RC4_DROP_EN
                  if (DROP_N > 0) begin
                     state    <= DROP;
                     drop_cnt <= '0;
                  end else begin
                     state     <= RUN;
                     busy      <= 1'b0;
                     init_done <= 1'b1;
                  end
`else
                  state     <= RUN;
                  busy      <= 1'b0;
                  init_done <= 1'b1;
`endif
               end
            end

`ifdef RC4_DROP_EN
            DROP: begin
               if (drop_cnt == 16'(DROP_N - 1)) begin
                  state     <= RUN;
                  busy      <= 1'b0;
                  init_done <= 1'b1;
               end else begin
                  drop_cnt <= drop_cnt + 16'd1;
               end
            end
`endif

            RUN: begin
               if (accept) begin
                  m_data  <= s_data ^ ks;
                  m_valid <= 1'b1;
               end else if (m_ready) begin
                  m_valid <= 1'b0;
               end
            end

            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rc4_stream_cipher.sv
// -----------------------------------------------------------------------------
// tb_rc4_stream_cipher
// Self-checking bench: known-answer vectors, round trip, rekey/abort, illegal
// start, asynchronous reset, and randomized keys/data with random stalls
// against a plain-array RC4 reference model.
// -----------------------------------------------------------------------------
module tb_rc4_stream_cipher;

   localparam int KB  = 16;
   localparam int KLW = $clog2(KB + 1);
`ifdef RC4_DROP_EN
   localparam int DROP = 3;
`else
   localparam int DROP = 0;
`endif

   logic            clk;
   logic            rst;
   logic [KB*8-1:0] key;
   logic [KLW-1:0]  key_len;
   logic            start;
   logic [7:0]      s_data;
   logic            s_valid;
   logic            s_ready;
   logic [7:0]      m_data;
   logic            m_valid;
   logic            m_ready;
   logic            init_done;
   logic            busy;

   rc4_stream_cipher #(.KEY_BYTES(KB), .DROP_N(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .key       (key),
      .key_len   (key_len),
      .start     (start),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .init_done (init_done),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Strings and hex constants are right-aligned; byte k of an n-byte value
   // in reading order.
   function automatic logic [7:0] rd(input logic [127:0] v, input int n, input int k);
      return v[8*(n-1-k) +: 8];
   endfunction

   // ---------------- reference model ----------------
   int         ms [256];
   int         mi;
   int         mj;
   logic [7:0] mk [KB];
   int         mklen;

   task automatic model_next(output logic [7:0] k);
      int t;
      mi = (mi + 1) % 256;
      mj = (mj + ms[mi]) % 256;
      t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
      k = 8'(ms[(ms[mi] + ms[mj]) % 256]);
   endtask

   task automatic model_init();
      int t;
      int j;
      logic [7:0] d;
      for (int c = 0; c < 256; c++) ms[c] = c;
      j = 0;
      for (int i = 0; i < 256; i++) begin
         j = (j + ms[i] + int'(mk[i % mklen])) % 256;
         t = ms[i]; ms[i] = ms[j]; ms[j] = t;
      end
      mi = 0;
      mj = 0;
      for (int n = 0; n < DROP; n++) model_next(d);
   endtask

   task automatic set_key_str(input logic [127:0] v, input int n);
      mklen = n;
      for (int k = 0; k < KB; k++) mk[k] = (k < n) ? rd(v, n, k) : 8'h00;
   endtask

   // ---------------- stimulus helpers (called at posedge + 1) ----------------
   logic [7:0] in_q [$];
   logic [7:0] out_q [$];

   task automatic rekey(output int lat);
      for (int k = 0; k < KB; k++) key[8*k +: 8] = mk[k];
      key_len = KLW'(mklen);
      start   = 1'b1;
      @(negedge clk);
      check("start_sready_low", 32'(s_ready), 0);
      @(posedge clk); #1;
      start   = 1'b0;
      s_valid = 1'b0;
      check("start_mvalid_low", 32'(m_valid), 0);
      check("start_busy", 32'(busy), 1);
      lat = 0;
      while (!init_done && lat < 1000) begin
         @(posedge clk); #1;
         lat++;
      end
      model_init();
   endtask

   task automatic stream(input bit stall);
      int idx;
      int cyc;
      int bp;
      idx = 0; cyc = 0; bp = 0;
      out_q.delete();
      while (out_q.size() < in_q.size() && cyc < 40 * in_q.size() + 100) begin
         s_valid = (idx < in_q.size()) && (!stall || $urandom_range(0, 3) != 0);
         s_data  = (idx < in_q.size()) ? in_q[idx] : 8'h00;
         m_ready = !stall || ($urandom_range(0, 2) != 0);
         @(negedge clk);
         if (m_valid && !m_ready && s_ready) bp++;
         if (s_valid && s_ready) idx++;
         if (m_valid && m_ready) out_q.push_back(m_data);
         @(posedge clk); #1;
         cyc++;
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      check("out_count", 32'(out_q.size()), 32'(in_q.size()));
      if (stall) check("bp_sready_low", 32'(bp), 0);
   endtask

   task automatic load_str(input logic [127:0] v, input int n);
      in_q.delete();
      for (int k = 0; k < n; k++) in_q.push_back(rd(v, n, k));
   endtask

   // Compare out_q against in_q XOR the model keystream.
   task automatic check_vs_model(input string name);
      logic [7:0] k;
      for (int b = 0; b < in_q.size() && b < out_q.size(); b++) begin
         model_next(k);
         check(name, 32'(out_q[b]), 32'(in_q[b] ^ k));
      end
   endtask

   typedef struct {
      logic [127:0] key;
      int           klen;
      logic [127:0] pt;
      int           n;
      logic [127:0] ct;
      bit           stall;
   } vec_t;

   vec_t vecs [$];

   initial begin
      int lat;
      int cnt;
      logic [7:0] ct_q [$];

`ifndef RC4_DROP_EN
      vecs.push_back('{128'("Key"),    3, 128'("Plaintext"),      9,
                       128'hBBF316E8D940AF0AD3, 1'b0});
      vecs.push_back('{128'("Secret"), 6, 128'("Attack at dawn"), 14,
                       128'h45A01F645FC35B383552544B9BF5, 1'b1});
      vecs.push_back('{128'("Wiki"),   4, 128'("pedia"),          5,
                       128'h1021BF0420, 1'b0});
`else
      vecs.push_back('{128'("Key"),    3, 128'("Pla"),            3,
                       128'hD1DB55, 1'b0});
`endif

      rst = 1'b1; start = 1'b0; key = '0; key_len = '0;
      s_data = 8'h00; s_valid = 1'b0; m_ready = 1'b1;
      #12;
      check("rst_m_valid", 32'(m_valid), 0);
      check("rst_m_data", 32'(m_data), 0);
      check("rst_init_done", 32'(init_done), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_s_ready", 32'(s_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Illegal start in IDLE is ignored; no input accepted.
      s_valid = 1'b1; key_len = '0; start = 1'b1;
      @(negedge clk);
      check("idle_s_ready", 32'(s_ready), 0);
      @(posedge clk); #1;
      start = 1'b0; s_valid = 1'b0;
      check("idle_illegal_start_busy", 32'(busy), 0);

      // Known-answer vectors.
      foreach (vecs[v]) begin
         set_key_str(vecs[v].key, vecs[v].klen);
         rekey(lat);
         check("init_latency", 32'(lat), 32'(512 + DROP));
         load_str(vecs[v].pt, vecs[v].n);
         stream(vecs[v].stall);
         for (int b = 0; b < vecs[v].n && b < out_q.size(); b++)
            check("kat_byte", 32'(out_q[b]), 32'(rd(vecs[v].ct, vecs[v].n, b)));
      end

      // Round trip with the same key.
      set_key_str(128'("Wiki"), 4);
      rekey(lat);
      load_str(128'("pedia"), 5);
      stream(1'b0);
      ct_q = out_q;
      rekey(lat);
      in_q = ct_q;
      stream(1'b1);
      for (int b = 0; b < 5 && b < out_q.size(); b++)
         check("roundtrip", 32'(out_q[b]), 32'(rd(128'("pedia"), 5, b)));

      // Rekey mid-stream with a pending output byte and a same-cycle s_valid.
      set_key_str(128'("Key"), 3);
      rekey(lat);
      load_str(128'("Plai"), 4);
      stream(1'b0);
      check_vs_model("mid_first4");
      s_valid = 1'b1; s_data = 8'h6E; m_ready = 1'b0;
      @(posedge clk); #1;
      check("pending_valid", 32'(m_valid), 1);
      m_ready = 1'b1;
      rekey(lat);
      check("rekey_latency", 32'(lat), 32'(512 + DROP));
      load_str(128'("Plaintext"), 9);
      stream(1'b0);
      check_vs_model("rekey_restart");

      // Illegal key lengths in RUN are ignored; keystream continues.
      key_len = '0; start = 1'b1;
      @(posedge clk); #1;
      key_len = KLW'(KB + 1);
      @(posedge clk); #1;
      start = 1'b0;
      check("illegal_run_init_done", 32'(init_done), 1);
      check("illegal_run_busy", 32'(busy), 0);
      load_str(128'("xyz"), 3);
      stream(1'b0);
      check_vs_model("illegal_continue");

      // Asynchronous reset mid-KSA, with a nonzero m_data left over.
      s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b0;
      @(posedge clk); #1;
      s_valid = 1'b0; m_ready = 1'b1;
      key_len = KLW'(3); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (300) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst_m_valid", 32'(m_valid), 0);
      check("arst_m_data", 32'(m_data), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_init_done", 32'(init_done), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      s_valid = 1'b1;
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (s_ready) cnt++;
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      check("post_rst_s_ready_low", 32'(cnt), 0);
      check("post_rst_idle", 32'(busy), 0);
      rekey(lat);
      check("post_rst_latency", 32'(lat), 32'(512 + DROP));
      load_str(128'("Pla"), 3);
      stream(1'b0);
      check_vs_model("post_rst_data");

      // Randomized keys and data with stalls.
      for (int r = 0; r < 3; r++) begin
         mklen = $urandom_range(1, KB);
         for (int k = 0; k < KB; k++) mk[k] = 8'($urandom_range(0, 255));
         rekey(lat);
         check("rand_latency", 32'(lat), 32'(512 + DROP));
         in_q.delete();
         for (int b = 0; b < 30; b++) in_q.push_back(8'($urandom_range(0, 255)));
         stream(1'b1);
         check_vs_model("rand_byte");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rc4_stream_cipher.md
Name: rc4_stream_cipher

Overview:
- Parametrised RC4 stream cipher: on-chip key scheduling (KSA) plus keystream generation (PRGA), XORed with a byte stream under valid/ready handshakes.
- The same operation encrypts and decrypts.
- Sits between a byte source (UART RX or text buffer) and a byte sink.
- Supports variable key length, rekey at any time, and optional RC4-drop[N] keystream discard.

Parameters:
- KEY_BYTES, 16, maximum key length in bytes; valid range 1..256.
- DROP_N, 256, number of initial keystream bytes discarded when RC4_DROP_EN is defined; valid range 0..65535.
- KLW, $clog2(KEY_BYTES+1), width of key_len (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- key  in  KEY_BYTES*8  key; byte k is key[8k+7:8k]. Sampled on the start cycle.
- key_len  in  KLW  number of key bytes used (1..KEY_BYTES). Sampled on the start cycle.
- start  in  1  single-cycle pulse that begins (re)keying.
- s_data  in  8  input byte (plaintext or ciphertext).
- s_valid  in  1  input byte valid.
- s_ready  out  1  block accepts the input byte.
- m_data  out  8  s_data XOR keystream byte.
- m_valid  out  1  output byte valid.
- m_ready  in  1  sink accepts the output byte.
- init_done  out  1  high while in RUN (keystream ready).
- busy  out  1  high in FILL, KSA or DROP.

Behaviour:
- Reset values (asynchronous): state=IDLE; i=0; j=0; m_valid=0; m_data=0; init_done=0; busy=0. S-box contents are don't-care after reset.
- S-box storage: 256x8 register array with combinational read.
- FSM states: IDLE, FILL, KSA, DROP, RUN.
- IDLE: s_ready=0. start with 1<=key_len<=KEY_BYTES latches key and key_len, then goes to FILL. start with an illegal key_len is ignored in every state.
- FILL: write S[c]=c for c=0..255, one entry per cycle (256 cycles). Then j=0, go to KSA.
- KSA: for i=0..255, one i per cycle:
  - j = j + S[i] + key[i mod key_len], mod 256;
  - swap S[i], S[j].
  - 256 cycles. Then i=0, j=0, go to DROP (feature on and DROP_N>0) or RUN.
- PRGA step, one per cycle:
  - i' = i+1; j' = j + S[i'];
  - swap S[i'], S[j'];
  - K = S[(S[i']+S[j']) mod 256], using the pre-swap values, which equals the post-swap sum.
  - All arithmetic is 8-bit wrap-around.
- DROP: perform DROP_N PRGA steps with the keystream discarded, using a 16-bit counter. Then go to RUN.
- RUN:
  - s_ready = !m_valid || m_ready.
  - On s_valid && s_ready: one PRGA step; m_data <= s_data ^ K; m_valid <= 1.
  - Otherwise, on m_ready: m_valid <= 0.
  - Latency is 1 cycle. Throughput is 1 byte/cycle under continuous ready.
  - The keystream advances only on an accepted input byte. Backpressure stalls the keystream with no byte lost or duplicated.
- Total init latency: start to init_done = 512 cycles (+DROP_N with the feature on).
  - init_done rises on the first RUN cycle.
  - busy is high exactly in FILL, KSA and DROP.
- Legal start while not IDLE (mid-operation rekey):
  - abort immediately; m_valid <= 0 (a pending output byte is dropped); go to FILL with the new key.
  - start has priority over a same-cycle s_valid handshake; that byte is not accepted (s_ready forced to 0 on a start cycle).
- rst mid-operation returns to IDLE; start is required before any further data.
- s_ready=0 in all states except RUN.

Optional Feature:
- Macro RC4_DROP_EN.
- Defined: DROP state present; the first DROP_N keystream bytes after every KSA are discarded (RC4-drop[N]).
- Undefined: DROP state and counter are not synthesised; KSA goes directly to RUN; DROP_N is ignored.

Decomposition:
- Package rc4_pkg:
  - state enum (IDLE, FILL, KSA, DROP, RUN);
  - SBOX_SIZE=256;
  - byte typedef.
- Sub-module rc4_keystream: S-box array, i/j registers, FILL/KSA/PRGA datapath, step/K interface.
- Top rc4_stream_cipher: FSM, drop counter, handshake, output register.

Test Plan:
- key="Key" (4B 65 79), key_len=3, feature off; stream "Plaintext" with m_ready=1 -> m_data BB F3 16 E8 D9 40 AF 0A D3. init_done rises exactly 512 cycles after start.
- key="Secret", key_len=6; "Attack at dawn" with random m_ready/s_valid stalls -> 45 A0 1F 64 5F C3 5B 38 35 52 54 4B 9B F5, no loss or duplication. s_ready=0 whenever m_valid && !m_ready.
- Round trip: encrypt with key="Wiki" -> 10 21 BF 04 20 for "pedia"; rekey with the same key and feed the ciphertext back -> "pedia" restored.
- Rekey mid-stream: start with key="Key" after 4 "Plaintext" bytes; m_valid drops; after 512 cycles, "Plaintext" -> BB F3 16 ... (restart from the first keystream byte). start with key_len=0 -> ignored, state unchanged.
- Async reset: assert rst mid-KSA between clock edges -> outputs zero immediately; s_ready=0 until start + 512 cycles.
- RC4_DROP_EN, DROP_N=3, key="Key": init_done at 515 cycles; "Pla" -> 50^81, 6C^B7, 61^34 = D1 DB 55.
